// File: rtl/soc_dbg_pkg.sv
// Shared command/response byte codes and FSM state type for the UART debug bus master.
package soc_dbg_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STAT = 8'h53;  // 'S'

    localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'
    localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        RESP
    } dbg_state_e;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Bus-wait counter: cleared on BUS entry, counts stalled cycles, flags the last allowed cycle.
module dbg_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Asserted in the cycle whose stall would bring the count to TIMEOUT.
    assign last = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_dbg_master.sv
// Host-byte-stream debug master: parses W/R/S commands and issues single-beat bus transactions.
module uart_dbg_master
    import soc_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] m_addr,
    output logic [7:0] m_wdata,
    output logic       m_we,
    output logic       m_valid,
    input  logic [7:0] m_rdata,
    input  logic       m_ready,
    output logic       busy,
    output logic       overrun
);

    dbg_state_e state, state_nxt;
    logic       rx_drop;
    logic       stat_clr;
    logic       tmo_last;
    logic       bus_enter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_drop   = 1'b0;
        m_valid   = (state == BUS);
        tx_valid  = (state == RESP);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_nxt = GET_ADDR;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    state_nxt = m_we ? GET_DATA : BUS;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                rx_drop = rx_valid;
                if (m_ready || tmo_last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rx_drop = rx_valid;
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus_enter = (state_nxt == BUS) && (state != BUS);
    assign stat_clr  = (state == IDLE) && rx_valid && (rx_data == CMD_STAT);

    dbg_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus_enter),
        .inc   ((state == BUS) && !m_ready),
        .last  (tmo_last)
    );

    // Command kind is latched from the first byte so m_we is settled before BUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            m_we    <= (rx_data == CMD_WR);
                            m_wdata <= '0;
                        end else if (rx_data == CMD_STAT) begin
                            tx_data <= {7'b0, overrun};
                        end else begin
                            tx_data <= RSP_BAD;
                        end
                    end
                end
                GET_ADDR: if (rx_valid) m_addr <= rx_data;
                GET_DATA: if (rx_valid) m_wdata <= rx_data;
                BUS: begin
                    if (m_ready) begin
                        tx_data <= m_we ? RSP_OK : m_rdata;
                    end else if (tmo_last) begin
                        tx_data <= RSP_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (rx_drop) begin
            overrun <= 1'b1;
        end else if (stat_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_dbg_master.sv
// Randomised bench for uart_dbg_master against a command-level reference model.
module tb_uart_dbg_master;

    localparam int unsigned TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic       m_we;
    logic       m_valid;
    logic [7:0] m_rdata = '0;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit model_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_dbg_master #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_we     (m_we),
        .m_valid  (m_valid),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Idle cycles inside a partial command: must keep waiting with no bus/response activity.
    task automatic gap(input int n);
        bit ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (!(busy === 1'b1 && m_valid === 1'b0 && tx_valid === 1'b0)) ok = 1'b0;
        end
        if (n > 0) chk("partial_wait", ok, 1);
    endtask

    // ready_at: BUS cycle (1-based) at which m_ready is given; 0 or > TMO means never.
    task automatic bus_phase(input logic [7:0] addr, input bit we, input logic [7:0] wd,
                             input logic [7:0] rd, input int ready_at, input bit drop,
                             output logic [7:0] exp_rsp);
        bit ok = 1'b1;
        bit done = 1'b0;
        exp_rsp = 8'h45;
        for (int c = 1; c <= int'(TMO) && !done; c++) begin
            if (!(m_valid === 1'b1 && m_addr === addr && m_we === we && m_wdata === wd &&
                  busy === 1'b1 && tx_valid === 1'b0)) ok = 1'b0;
            if (drop && c == 1) begin
                rx_valid  = 1'b1;
                rx_data   = 8'($urandom);
                model_ovr = 1'b1;
            end
            if (c == ready_at) begin
                m_ready = 1'b1;
                m_rdata = rd;
                exp_rsp = we ? 8'h4B : rd;
                done    = 1'b1;
            end
            step();
            rx_valid = 1'b0;
            m_ready  = 1'b0;
            m_rdata  = 8'($urandom);
        end
        chk("bus_request", ok, 1);
        chk("bus_release", m_valid, 0);
        chk("reply_valid", tx_valid, 1);
        chk("reply_data", tx_data, exp_rsp);
    endtask

    task automatic resp_phase(input logic [7:0] exp, input int hold, input bit drop);
        bit ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!(tx_valid === 1'b1 && tx_data === exp && busy === 1'b1)) ok = 1'b0;
        end
        if (hold > 0) chk("reply_hold", ok, 1);
        tx_ready = 1'b1;
        if (drop) begin
            rx_valid  = 1'b1;
            rx_data   = 8'($urandom);
            model_ovr = 1'b1;
        end
        step();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        chk("back_to_idle", {tx_valid, busy}, 0);
        chk("overrun_flag", overrun, model_ovr);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int ready_at,
                            input int gp, input bit drop_bus, input int hold, input bit drop_rsp);
        logic [7:0] e;
        send(8'h57);
        gap(gp);
        send(a);
        gap(gp);
        send(d);
        bus_phase(a, 1'b1, d, 8'($urandom), ready_at, drop_bus, e);
        resp_phase(e, hold, drop_rsp);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] rd, input int ready_at,
                           input int gp, input bit drop_bus, input int hold, input bit drop_rsp);
        logic [7:0] e;
        send(8'h52);
        gap(gp);
        send(a);
        bus_phase(a, 1'b0, 8'h00, rd, ready_at, drop_bus, e);
        resp_phase(e, hold, drop_rsp);
    endtask

    task automatic do_simple(input logic [7:0] b, input int hold, input bit drop_rsp);
        logic [7:0] e;
        if (b == 8'h53) begin
            e = {7'b0, model_ovr};
            model_ovr = 1'b0;
        end else begin
            e = 8'h3F;
        end
        send(b);
        chk("simple_valid", tx_valid, 1);
        chk("simple_data", tx_data, e);
        chk("simple_no_bus", m_valid, 0);
        resp_phase(e, hold, drop_rsp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {tx_valid, tx_data, m_valid, m_we, m_addr, m_wdata, busy, overrun}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", {busy, m_valid, tx_valid}, 0);

        do_write(8'h10, 8'hA5, 2, 0, 1'b0, 0, 1'b0);
        do_read(8'h82, 8'h3C, 1, 0, 1'b0, 5, 1'b0);
        do_simple(8'h00, 1, 1'b0);
        do_simple(8'h53, 0, 1'b0);
        do_read(8'h21, 8'h77, 0, 0, 1'b0, 0, 1'b0);
        do_read(8'h22, 8'h99, int'(TMO), 0, 1'b0, 0, 1'b0);
        do_write(8'h05, 8'h5A, 3, 1, 1'b1, 0, 1'b0);
        do_simple(8'h53, 0, 1'b0);
        do_simple(8'h53, 0, 1'b0);
        do_simple(8'h41, 2, 1'b1);
        do_simple(8'h53, 0, 1'b0);

        send(8'h52);
        send(8'h44);
        chk("bus_before_reset", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {m_valid, tx_valid, busy, overrun}, 0);
        model_ovr = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_read(8'h44, 8'hC3, 1, 0, 1'b0, 0, 1'b0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: do_write(8'($urandom), 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 2),
                            1'($urandom), $urandom_range(0, 3), 1'($urandom));
                1: do_read(8'($urandom), 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 2),
                           1'($urandom), $urandom_range(0, 3), 1'($urandom));
                2: do_simple(8'h53, $urandom_range(0, 3), 1'($urandom));
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h57 || b == 8'h52 || b == 8'h53) b = 8'($urandom);
                    do_simple(b, $urandom_range(0, 3), 1'($urandom));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
